// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle i_min - i_sub, BITS_PER_CYCLE bits per clock,
// LSB first, one borrow flop, valid/ready on both sides.
module serial_subtractor #(
    parameter int N              = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_min,
    input  logic [N-1:0] i_sub,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [N-1:0] o_result,
    output logic         o_borrow,
    output logic         o_overflow,
    output logic         o_valid,
    input  logic         i_ready
);

    localparam int STEPS = N / BITS_PER_CYCLE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    if ((N % BITS_PER_CYCLE) != 0) begin : g_bpc_check
        $error("serial_subtractor: BITS_PER_CYCLE must divide N");
    end

    logic [1:0]                state;
    logic [N-1:0]              min_sr;
    logic [N-1:0]              sub_sr;
    logic [N-1:0]              res_sr;
    logic                      borrow;
    logic [CW-1:0]             cnt;
    logic                      min_msb;
    logic                      sub_msb;

    logic [BITS_PER_CYCLE:0]   slice_diff;
    logic [BITS_PER_CYCLE-1:0] d;
    logic                      b_out;
    logic [N-1:0]              res_next;
    logic                      ovf_next;

    // One slice of the ripple: the extra top bit of the difference is the borrow out.
    always_comb begin
        slice_diff = {1'b0, min_sr[BITS_PER_CYCLE-1:0]}
                   - {1'b0, sub_sr[BITS_PER_CYCLE-1:0]}
                   - {{BITS_PER_CYCLE{1'b0}}, borrow};
        d     = slice_diff[BITS_PER_CYCLE-1:0];
        b_out = slice_diff[BITS_PER_CYCLE];
    end

    // Difference slices enter the result register from the MSB side.
    if (BITS_PER_CYCLE == N) begin : g_res_full
        assign res_next = d;
    end else begin : g_res_shift
        assign res_next = {d, res_sr[N-1:BITS_PER_CYCLE]};
    end

    // Signed overflow only possible when operand signs differ.
    assign ovf_next = (min_msb != sub_msb) & (res_next[N-1] != min_msb);

    // Handshake FSM, shift datapath and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            min_sr     <= '0;
            sub_sr     <= '0;
            res_sr     <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
            min_msb    <= 1'b0;
            sub_msb    <= 1'b0;
            o_ready    <= 1'b1;
            o_valid    <= 1'b0;
            o_result   <= '0;
            o_borrow   <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        min_sr  <= i_min;
                        sub_sr  <= i_sub;
                        min_msb <= i_min[N-1];
                        sub_msb <= i_sub[N-1];
                        borrow  <= 1'b0;
                        cnt     <= '0;
                        o_ready <= 1'b0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    min_sr <= min_sr >> BITS_PER_CYCLE;
                    sub_sr <= sub_sr >> BITS_PER_CYCLE;
                    res_sr <= res_next;
                    borrow <= b_out;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt        <= '0;
                        o_result   <= res_next;
                        o_borrow   <= b_out;
                        o_overflow <= ovf_next;
                        o_valid    <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Multi-cycle unsigned/two's-complement subtractor computing i_min - i_sub. It processes BITS_PER_CYCLE bits per clock, LSB first, with a single borrow flop, so it trades latency for area against the parallel adder datapath. It takes operands through a valid/ready input handshake and returns the difference plus borrow and signed-overflow flags through a valid/ready output handshake. It sits beside the adder blocks as the area-lean subtract path.

Parameters:
N, 16, operand and result width in bits
BITS_PER_CYCLE, 1, bits processed per clock; must divide N exactly (elaboration error otherwise)

Ports:
i_clk  input  1  clock, rising-edge active
i_rst  input  1  reset, asynchronous, active-high
i_min  input  N  minuend, sampled on input handshake
i_sub  input  N  subtrahend, sampled on input handshake
i_valid  input  1  operands valid
o_ready  output  1  block can accept operands
o_result  output  N  difference i_min - i_sub mod 2^N
o_borrow  output  1  1 when i_min < i_sub (unsigned)
o_overflow  output  1  signed two's-complement overflow
o_valid  output  1  result and flags valid
i_ready  input  1  consumer accepts result

Behaviour:
- Reset is asynchronous, active-high, one clock i_clk. While i_rst=1 and on release: state IDLE, o_ready=1, o_valid=0, o_result=0, o_borrow=0, o_overflow=0, internal borrow=0, counter=0.
- States: IDLE, CALC, HOLD. All outputs are registered.
- IDLE: o_ready=1, o_valid=0.
  - On i_valid=1 at an edge: capture i_min/i_sub into shift regs, clear borrow and counter, go to CALC, o_ready=0 next cycle.
- CALC: o_ready=0, o_valid=0.
  - Each cycle: slice = low BITS_PER_CYCLE bits of each shift reg; {b_out, d} = slice_min - slice_sub - borrow.
  - d shifts into the result reg from the MSB side; operand regs shift right by BITS_PER_CYCLE; borrow <= b_out; counter increments.
  - The last slice is processed on CALC cycle N/BITS_PER_CYCLE, which is also the last CALC cycle. At that edge, update o_result, o_borrow (final b_out) and o_overflow = (min[N-1] != sub[N-1]) & (result[N-1] != min[N-1]). Then go to HOLD with o_valid=1.
- Latency: if operands are accepted at edge k, o_valid=1 after edge k + N/BITS_PER_CYCLE. Defaults give 16 cycles; BITS_PER_CYCLE=4 gives 4 cycles.
- HOLD: o_valid=1, o_ready=0. o_result and the flags stay stable for any number of i_ready=0 cycles.
  - On i_ready=1 at an edge: o_valid=0, o_ready=1, go to IDLE.
  - No new operand is accepted in the same edge as result handoff. Minimum issue interval is N/BITS_PER_CYCLE + 2 cycles.
- i_valid in CALC or HOLD is ignored; operands are not queued.
- i_ready outside HOLD is ignored.
- o_result/o_borrow/o_overflow keep their last values in IDLE and CALC. They change only at the CALC-to-HOLD edge.
- i_min == i_sub: result 0, borrow 0, overflow 0.
- Full-range wrap: result is always mod 2^N; the borrow flag is the only unsigned-underflow indication.
- Reset mid-CALC or mid-HOLD: the operation is aborted, the result is discarded, and all outputs go to reset values immediately (asynchronously).

Test Plan:
1. N=16, BPC=1: i_min=0x0005, i_sub=0x0003, i_ready=1 -> o_valid after 16 cycles; o_result=0x0002, borrow=0, overflow=0; o_ready=1 one cycle later.
2. i_min=0x0003, i_sub=0x0005 -> o_result=0xFFFE, borrow=1, overflow=0. Then i_min=0x8000, i_sub=0x0001 -> 0x7FFF, borrow=0, overflow=1. Then i_min=0x7FFF, i_sub=0xFFFF -> 0x8000, borrow=1, overflow=1.
3. Backpressure: hold i_ready=0 for 10 cycles in HOLD -> o_valid stays 1, outputs stable, o_ready=0. Pulse i_valid with different operands during HOLD -> ignored; the next accepted result matches the next handshake only.
4. Reset mid-CALC: assert i_rst at CALC cycle 7 -> outputs 0 and o_ready=1 without waiting for a clock edge. A fresh operation 0x1234-0x0234 then gives 0x1000.
5. BPC=4: i_min=0x0000, i_sub=0x0001 -> o_valid after exactly 4 cycles; result=0xFFFF, borrow=1, overflow=0.
6. Back-to-back with i_valid held high and i_ready held high: 200 random operand pairs -> every result and both flags match the reference model. Issue interval is exactly N/BPC+2 cycles, and no handshake is lost or duplicated.
